dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 23 ++
 rtl/dmem_arb_pick.sv | 45 ++++
 rtl/dmem_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// burst defaults and the beat counter helper.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam int BURST_MAX_DEFAULT = 4;
  localparam int BEAT_W            = 4;
  localparam logic [BEAT_W-1:0] BEAT_SAT = 4'd15;

  // Beat counter advance that sticks at its ceiling instead of wrapping.
  function automatic logic [BEAT_W-1:0] beat_sat_inc(input logic [BEAT_W-1:0] cnt);
    if (cnt == BEAT_SAT) begin
      return BEAT_SAT;
    end
    return cnt + 4'd1;
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection for the two-port data-memory arbiter.
// Ties go round robin from IDLE; an owning port keeps the bus until its burst limit.
module dmem_arb_pick
  import dmem_arbiter_pkg::*;
#(
  parameter int BURST_MAX = BURST_MAX_DEFAULT
) (
  input  arb_state_e        state,
  input  logic              req0,
  input  logic              req1,
  input  logic [BEAT_W-1:0] beat_cnt,
  input  logic              last_winner,
  output logic              gnt0,
  output logic              gnt1
);

  localparam logic [BEAT_W-1:0] BURST_LIM = BEAT_W'(BURST_MAX);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && !req1) begin
      gnt0 = 1'b1;
    end else if (req1 && !req0) begin
      gnt1 = 1'b1;
    end else if (req0 && req1) begin
      // Contention: the current owner continues only while under its burst limit.
      case (state)
        OWN0: begin
          if (beat_cnt < BURST_LIM) gnt0 = 1'b1;
          else                      gnt1 = 1'b1;
        end
        OWN1: begin
          if (beat_cnt < BURST_LIM) gnt1 = 1'b1;
          else                      gnt0 = 1'b1;
        end
        default: begin
          if (last_winner) gnt0 = 1'b1;
          else             gnt1 = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: one access per cycle to a shared single-port
// memory with bounded bursts, round-robin ties and one-cycle read return.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int BURST_MAX = BURST_MAX_DEFAULT,
  parameter int AW        = 16,
  parameter int DW        = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_e        state;
  arb_state_e        state_next;
  logic [BEAT_W-1:0] beat_cnt;
  logic [BEAT_W-1:0] beat_next;
  logic              last_winner;
  logic              last_next;
  logic              rvalid0_q;
  logic              rvalid1_q;
  logic              pick_gnt0;
  logic              pick_gnt1;

  dmem_arb_pick #(
    .BURST_MAX (BURST_MAX)
  ) u_pick (
    .state       (state),
    .req0        (req0),
    .req1        (req1),
    .beat_cnt    (beat_cnt),
    .last_winner (last_winner),
    .gnt0        (pick_gnt0),
    .gnt1        (pick_gnt1)
  );

  // Reset silences the bus immediately rather than waiting for the next edge.
  assign gnt0 = pick_gnt0 & ~reset;
  assign gnt1 = pick_gnt1 & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      last_winner <= 1'b1;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
    end else begin
      state       <= state_next;
      beat_cnt    <= beat_next;
      last_winner <= last_next;
      rvalid0_q   <= gnt0 & ~we0;
      rvalid1_q   <= gnt1 & ~we1;
    end
  end

  // The next state is simply whoever got the bus this cycle; beats restart on an owner change.
  always_comb begin
    state_next = IDLE;
    beat_next  = '0;
    last_next  = last_winner;
    if (gnt0) begin
      state_next = OWN0;
      last_next  = 1'b0;
      beat_next  = (state == OWN0) ? beat_sat_inc(beat_cnt) : 4'd1;
    end else if (gnt1) begin
      state_next = OWN1;
      last_next  = 1'b1;
      beat_next  = (state == OWN1) ? beat_sat_inc(beat_cnt) : 4'd1;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (gnt0) begin
      mem_addr  = addr0;
      mem_wdata = wdata0;
      mem_we    = we0;
      mem_re    = ~we0;
    end else if (gnt1) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
      mem_we    = we1;
      mem_re    = ~we1;
    end
  end

  // A read in flight when reset rises is dropped; the requester reissues it.
  always_comb begin
    rvalid0 = rvalid0_q & ~reset;
    rvalid1 = rvalid1_q & ~reset;
    rdata0  = rvalid0 ? mem_rdata : '0;
    rdata1  = rvalid1 ? mem_rdata : '0;
  end

endmodule
